// File: rtl/counter_dff_sync_up_4bit_pkg.sv
// Shared constants, slice operation codes and load-clip helper for the
// synchronous up counter.
package counter_dff_sync_up_4bit_pkg;

    localparam int COUNTER_WIDTH = 4;
    localparam int MODULUS_MAX   = 16;
    localparam int MODULUS_BCD   = 10;

    typedef enum logic [1:0] {
        SLICE_HOLD  = 2'd0,
        SLICE_INC   = 2'd1,
        SLICE_CLEAR = 2'd2,
        SLICE_LOAD  = 2'd3
    } slice_op_e;

    // Anything at or above the terminal value saturates to it, which is the
    // same as clipping values >= MODULUS to MODULUS-1.
    function automatic logic [COUNTER_WIDTH-1:0] clip_load(
        input logic [COUNTER_WIDTH-1:0] din,
        input logic [COUNTER_WIDTH-1:0] tc_val
    );
        return (din >= tc_val) ? tc_val : din;
    endfunction

endpackage

// File: rtl/counter_dff_sync_up_4bit_count_stage_dff.sv
// One bit slice: next-state mux plus a D flip-flop with registered Q and Qbar.
module count_stage_dff
    import counter_dff_sync_up_4bit_pkg::*;
(
    input  logic      Clk,
    input  logic      ClrN,
    input  slice_op_e op_i,
    input  logic      load_bit_i,
    input  logic      inc_bit_i,
    output logic      q_o,
    output logic      qbar_o
);

    logic q_q;
    logic q_d;
    logic qbar_q;

    always_comb begin
        q_d = q_q;
        case (op_i)
            SLICE_LOAD:  q_d = load_bit_i;
            SLICE_INC:   q_d = inc_bit_i;
            SLICE_CLEAR: q_d = 1'b0;
            default:     q_d = q_q;
        endcase
    end

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            q_q    <= 1'b0;
            qbar_q <= 1'b1;
        end else begin
            q_q    <= q_d;
            qbar_q <= ~q_d;
        end
    end

    assign q_o    = q_q;
    assign qbar_o = qbar_q;

endmodule

// File: rtl/counter_dff_sync_up_4bit.sv
// Synchronous modulo-N up counter with parallel load, cascade carry and a
// registered wrap pulse; built from four count_stage_dff slices.
module counter_dff_sync_up_4bit
    import counter_dff_sync_up_4bit_pkg::*;
#(
    parameter int MODULUS = 16
) (
    input  logic                     Clk,
    input  logic                     ClrN,
    input  logic                     En,
    input  logic                     CarryIn,
    input  logic                     Load,
    input  logic [COUNTER_WIDTH-1:0] Din,
    output logic [COUNTER_WIDTH-1:0] Q,
    output logic [COUNTER_WIDTH-1:0] Qbar,
    output logic                     Tc,
    output logic                     CarryOut,
    output logic                     Wrap
);

    if (MODULUS < 2 || MODULUS > MODULUS_MAX) begin : g_bad_modulus
        $error("counter_dff_sync_up_4bit: MODULUS must be in 2..16");
    end

    localparam logic [COUNTER_WIDTH-1:0] TC_VAL = COUNTER_WIDTH'(MODULUS - 1);

    logic [COUNTER_WIDTH-1:0] q;
    logic [COUNTER_WIDTH-1:0] qbar;
    logic [COUNTER_WIDTH-1:0] q_inc;
    logic [COUNTER_WIDTH-1:0] din_clip;
    logic                     count;
    slice_op_e                op;
    logic                     wrap_q;
    logic                     wrap_d;

    assign count    = En & CarryIn;
    assign q_inc    = q + 4'd1;
    assign din_clip = clip_load(Din, TC_VAL);
    assign Tc       = (q == TC_VAL);
    assign CarryOut = Tc & count;

    // Values past the terminal count can only come from an upset; they clear
    // on the next counting edge like a wrap, but without the Wrap pulse.
    always_comb begin
        op     = SLICE_HOLD;
        wrap_d = 1'b0;
        if (Load) begin
            op = SLICE_LOAD;
        end else if (count) begin
            op     = (q >= TC_VAL) ? SLICE_CLEAR : SLICE_INC;
            wrap_d = Tc;
        end
    end

    for (genvar i = 0; i < COUNTER_WIDTH; i++) begin : g_stage
        count_stage_dff u_stage (
            .Clk        (Clk),
            .ClrN       (ClrN),
            .op_i       (op),
            .load_bit_i (din_clip[i]),
            .inc_bit_i  (q_inc[i]),
            .q_o        (q[i]),
            .qbar_o     (qbar[i])
        );
    end

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q;
    assign Qbar = qbar;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_counter_dff_sync_up_4bit.sv
// Bench: one modulo-16 counter plus a two-digit BCD cascade, checked every
// cycle against an arithmetic model, with directed scenarios then random.
module tb_counter_dff_sync_up_4bit;

    logic       Clk = 1'b0;
    logic       ClrN = 1'b0;

    logic       en16 = 1'b0, cin16 = 1'b0, ld16 = 1'b0;
    logic [3:0] din16 = 4'd0;
    logic [3:0] q16, qb16;
    logic       tc16, co16, wr16;

    logic       en_lo = 1'b0, cin_lo = 1'b0, ld_lo = 1'b0;
    logic [3:0] din_lo = 4'd0;
    logic [3:0] q_lo, qb_lo;
    logic       tc_lo, co_lo, wr_lo;

    logic       en_hi = 1'b0, ld_hi = 1'b0;
    logic [3:0] din_hi = 4'd0;
    logic [3:0] q_hi, qb_hi;
    logic       tc_hi, co_hi, wr_hi;

    counter_dff_sync_up_4bit #(.MODULUS(16)) u16 (
        .Clk(Clk), .ClrN(ClrN), .En(en16), .CarryIn(cin16), .Load(ld16), .Din(din16),
        .Q(q16), .Qbar(qb16), .Tc(tc16), .CarryOut(co16), .Wrap(wr16));

    counter_dff_sync_up_4bit #(.MODULUS(10)) u_lo (
        .Clk(Clk), .ClrN(ClrN), .En(en_lo), .CarryIn(cin_lo), .Load(ld_lo), .Din(din_lo),
        .Q(q_lo), .Qbar(qb_lo), .Tc(tc_lo), .CarryOut(co_lo), .Wrap(wr_lo));

    counter_dff_sync_up_4bit #(.MODULUS(10)) u_hi (
        .Clk(Clk), .ClrN(ClrN), .En(en_hi), .CarryIn(co_lo), .Load(ld_hi), .Din(din_hi),
        .Q(q_hi), .Qbar(qb_hi), .Tc(tc_hi), .CarryOut(co_hi), .Wrap(wr_hi));

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts as integers, modulo arithmetic from the rules.
    int mods[3] = '{16, 10, 10};
    int mq[3]   = '{0, 0, 0};
    bit mw[3]   = '{0, 0, 0};

    function automatic int nxt(int q, int m, bit ld, int din, bit cnt);
        if (ld) return (din >= m) ? m - 1 : din;
        if (!cnt) return q;
        if (q == m - 1 || q >= m) return 0;
        return q + 1;
    endfunction

    always @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            for (int i = 0; i < 3; i++) begin
                mq[i] = 0;
                mw[i] = 0;
            end
        end else begin
            bit c0, c1, c2, carry_lo;
            c0       = en16 && cin16;
            c1       = en_lo && cin_lo;
            carry_lo = (mq[1] == mods[1] - 1) && c1;
            c2       = en_hi && carry_lo;
            mw[0] = !ld16  && c0 && (mq[0] == mods[0] - 1);
            mw[1] = !ld_lo && c1 && (mq[1] == mods[1] - 1);
            mw[2] = !ld_hi && c2 && (mq[2] == mods[2] - 1);
            mq[0] = nxt(mq[0], mods[0], ld16,  int'(din16),  c0);
            mq[1] = nxt(mq[1], mods[1], ld_lo, int'(din_lo), c1);
            mq[2] = nxt(mq[2], mods[2], ld_hi, int'(din_hi), c2);
        end
    end

    task automatic check_all();
        bit e_tc0, e_tc1, e_tc2, e_co0, e_co1, e_co2;
        e_tc0 = (mq[0] == mods[0] - 1);
        e_tc1 = (mq[1] == mods[1] - 1);
        e_tc2 = (mq[2] == mods[2] - 1);
        e_co0 = e_tc0 && en16 && cin16;
        e_co1 = e_tc1 && en_lo && cin_lo;
        e_co2 = e_tc2 && en_hi && e_co1;
        chk("q16",    q16,   mq[0]);
        chk("qbar16", qb16,  15 - mq[0]);
        chk("tc16",   tc16,  e_tc0);
        chk("co16",   co16,  e_co0);
        chk("wrap16", wr16,  mw[0]);
        chk("q_lo",   q_lo,  mq[1]);
        chk("qbar_lo", qb_lo, 15 - mq[1]);
        chk("tc_lo",  tc_lo, e_tc1);
        chk("co_lo",  co_lo, e_co1);
        chk("wrap_lo", wr_lo, mw[1]);
        chk("q_hi",   q_hi,  mq[2]);
        chk("qbar_hi", qb_hi, 15 - mq[2]);
        chk("tc_hi",  tc_hi, e_tc2);
        chk("co_hi",  co_hi, e_co2);
        chk("wrap_hi", wr_hi, mw[2]);
    endtask

    always @(negedge Clk) check_all();

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_q16", q16, 0);
        chk("rst_qbar16", qb16, 15);
        ClrN = 1'b1;

        // Async clear mid-count at 7, then first count edge gives 1.
        en16 = 1'b1; cin16 = 1'b1;
        repeat (7) tick();
        chk("mid_q7", q16, 7);
        #1 ClrN = 1'b0;
        #1;
        check_all();
        chk("clr_q", q16, 0);
        chk("clr_qbar", qb16, 15);
        chk("clr_wrap", wr16, 0);
        chk("clr_co", co16, 0);
        ClrN = 1'b1;
        tick();
        chk("post_clr_q", q16, 1);

        // Run up to 15, then wrap.
        repeat (14) tick();
        chk("full_q15", q16, 15);
        chk("full_tc15", tc16, 1);
        tick();
        chk("full_wrap_q", q16, 0);
        chk("full_wrap", wr16, 1);
        tick();
        chk("full_after_q", q16, 1);
        chk("full_after_wrap", wr16, 0);

        // Load beats count on the same edge.
        ld16 = 1'b1; din16 = 4'd3;
        tick();
        chk("ld_q3", q16, 3);
        din16 = 4'd5;
        tick();
        chk("ld_prio_q", q16, 5);
        chk("ld_prio_wrap", wr16, 0);
        ld16 = 1'b0; en16 = 1'b0;
        repeat (10) tick();
        chk("hold_q5", q16, 5);

        // CarryIn gating at 15.
        ld16 = 1'b1; din16 = 4'd15;
        tick();
        ld16 = 1'b0; en16 = 1'b1; cin16 = 1'b0;
        tick();
        chk("gate_q", q16, 15);
        chk("gate_tc", tc16, 1);
        chk("gate_co", co16, 0);
        cin16 = 1'b1;
        #1;
        chk("gate_co_rise", co16, 1);
        tick();
        chk("gate_wrap_q", q16, 0);
        chk("gate_wrap", wr16, 1);

        // BCD digit pair.
        en_lo = 1'b1; cin_lo = 1'b1; en_hi = 1'b1;
        repeat (9) tick();
        chk("bcd_lo9", q_lo, 9);
        chk("bcd_co9", co_lo, 1);
        tick();
        chk("bcd_lo0", q_lo, 0);
        chk("bcd_wr", wr_lo, 1);
        chk("bcd_hi1", q_hi, 1);
        en_lo = 1'b0; ld_lo = 1'b1; din_lo = 4'd12;
        tick();
        chk("bcd_clip", q_lo, 9);
        ld_lo = 1'b0; en_lo = 1'b1;
        tick();
        chk("bcd_clip_wrap_q", q_lo, 0);
        chk("bcd_clip_wrap", wr_lo, 1);
        chk("bcd_hi2", q_hi, 2);

        // 09 -> 10
        en_lo = 1'b0; ld_lo = 1'b1; din_lo = 4'd9; ld_hi = 1'b1; din_hi = 4'd0;
        tick();
        ld_lo = 1'b0; ld_hi = 1'b0; en_lo = 1'b1;
        tick();
        chk("c09_lo", q_lo, 0);
        chk("c09_hi", q_hi, 1);
        chk("c09_wrlo", wr_lo, 1);
        chk("c09_wrhi", wr_hi, 0);

        // 99 -> 00
        en_lo = 1'b0; ld_lo = 1'b1; din_lo = 4'd9; ld_hi = 1'b1; din_hi = 4'd9;
        tick();
        ld_lo = 1'b0; ld_hi = 1'b0; en_lo = 1'b1;
        tick();
        chk("c99_lo", q_lo, 0);
        chk("c99_hi", q_hi, 0);
        chk("c99_wrlo", wr_lo, 1);
        chk("c99_wrhi", wr_hi, 1);

        // Random traffic; the per-cycle compare does the checking.
        repeat (800) begin
            en16   = ($urandom_range(0, 3) != 0);
            cin16  = ($urandom_range(0, 3) != 0);
            ld16   = ($urandom_range(0, 11) == 0);
            din16  = 4'($urandom_range(0, 15));
            en_lo  = ($urandom_range(0, 3) != 0);
            cin_lo = ($urandom_range(0, 3) != 0);
            ld_lo  = ($urandom_range(0, 11) == 0);
            din_lo = 4'($urandom_range(0, 15));
            en_hi  = ($urandom_range(0, 3) != 0);
            ld_hi  = ($urandom_range(0, 15) == 0);
            din_hi = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0) begin
                #1 ClrN = 1'b0;
                #1 ClrN = 1'b1;
            end
            tick();
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
